cache_refill_arbiter: RTL and testbench

- Shares the single off-chip memory port between I-cache line fills and D-cache line fills/write-backs.
- Sits between the two caches and the memory interface; the cache miss flags that drive ic_miss and dc_miss stall until this block returns done.
- Fixed D-over-I priority with an anti-starvation override, one transaction in flight, burst beat counting.

---
 rtl/cache_refill_arbiter_pkg.sv | 22 ++
 rtl/cache_refill_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_cache_refill_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_refill_arbiter_pkg.sv
// Shared types and helpers for the cache refill arbiter.
package cache_refill_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

  // Number of byte-offset bits inside one cache line.
  function automatic int unsigned line_offset_bits(input int unsigned words,
                                                   input int unsigned dw);
    return $clog2(words * dw / 8);
  endfunction

endpackage

// File: rtl/cache_refill_arbiter.sv
// Arbitrates the single memory port between I-cache fills and D-cache fills/write-backs.
// D has priority; I is forced after STARVE_LIMIT consecutive D grants while it waits.
module cache_refill_arbiter
  import cache_refill_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned LINE_WORDS   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic [DATA_WIDTH-1:0] ic_rd_data,
  output logic                  ic_rd_valid,
  output logic                  ic_done,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [DATA_WIDTH-1:0] dc_wr_data,
  output logic                  dc_wr_ready,
  output logic [DATA_WIDTH-1:0] dc_rd_data,
  output logic                  dc_rd_valid,
  output logic                  dc_done,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_we,
  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [1:0]            grant
);

  localparam int unsigned OFF_BITS = line_offset_bits(LINE_WORDS, DATA_WIDTH);
  localparam int unsigned BEAT_W   = $clog2(LINE_WORDS);
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);
  localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK  =
    ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));

  arb_state_t            state_q;
  arb_owner_t            owner_q;
  logic [1:0]            grant_q;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  last_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic                  req_we_q;
  logic                  req_valid_q;
  logic                  wr_valid_q;
  logic                  ic_rd_valid_q, dc_rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  ic_done_q, dc_done_q;

  logic any_req_c, pick_i_c, wr_beat_c, rd_beat_c;

  assign any_req_c = ic_req | dc_req;
  assign pick_i_c  = ic_req & (~dc_req | (starve_q == STARVE_MAX));
  assign wr_beat_c = wr_valid_q & mem_wr_ready;
  assign rd_beat_c = (state_q == ARB_DATA) & ~req_we_q & ~last_q & mem_rd_valid;

  // Starve counter: saturating count of D grants that bypassed a waiting I.
  always_comb begin
    starve_d = starve_q;
    if (state_q == ARB_IDLE && any_req_c) begin
      if (pick_i_c)
        starve_d = '0;
      else if (ic_req && starve_q != STARVE_MAX)
        starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_comb begin
    beat_d = beat_q;
    if (state_q == ARB_ADDR)
      beat_d = '0;
    else if (rd_beat_c || wr_beat_c)
      beat_d = beat_q + BEAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      owner_q       <= OWNER_I;
      grant_q       <= '0;
      beat_q        <= '0;
      starve_q      <= '0;
      last_q        <= 1'b0;
      req_addr_q    <= '0;
      req_we_q      <= 1'b0;
      req_valid_q   <= 1'b0;
      wr_valid_q    <= 1'b0;
      ic_rd_valid_q <= 1'b0;
      dc_rd_valid_q <= 1'b0;
      rd_data_q     <= '0;
      ic_done_q     <= 1'b0;
      dc_done_q     <= 1'b0;
    end else begin
      ic_rd_valid_q <= 1'b0;
      dc_rd_valid_q <= 1'b0;
      ic_done_q     <= 1'b0;
      dc_done_q     <= 1'b0;
      beat_q        <= beat_d;
      starve_q      <= starve_d;
      case (state_q)
        ARB_IDLE: begin
          if (any_req_c) begin
            state_q     <= ARB_ADDR;
            req_valid_q <= 1'b1;
            if (pick_i_c) begin
              owner_q    <= OWNER_I;
              grant_q    <= 2'b01;
              req_addr_q <= ic_addr & LINE_MASK;
              req_we_q   <= 1'b0;
            end else begin
              owner_q    <= OWNER_D;
              grant_q    <= 2'b10;
              req_addr_q <= dc_addr & LINE_MASK;
              req_we_q   <= dc_we;
            end
          end
        end
        ARB_ADDR: begin
          if (mem_req_ready) begin
            state_q     <= ARB_DATA;
            req_valid_q <= 1'b0;
            last_q      <= 1'b0;
            wr_valid_q  <= req_we_q;
          end
        end
        ARB_DATA: begin
          if (req_we_q) begin
            if (wr_beat_c && beat_q == LAST_BEAT) begin
              wr_valid_q <= 1'b0;
              state_q    <= ARB_DONE;
              dc_done_q  <= 1'b1;
            end
          end else if (last_q) begin
            // Last beat has been presented; completion follows one cycle later.
            state_q   <= ARB_DONE;
            ic_done_q <= (owner_q == OWNER_I);
            dc_done_q <= (owner_q == OWNER_D);
          end else if (mem_rd_valid) begin
            rd_data_q     <= mem_rd_data;
            ic_rd_valid_q <= (owner_q == OWNER_I);
            dc_rd_valid_q <= (owner_q == OWNER_D);
            if (beat_q == LAST_BEAT)
              last_q <= 1'b1;
          end
        end
        ARB_DONE: begin
          state_q <= ARB_IDLE;
          grant_q <= '0;
          last_q  <= 1'b0;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign ic_rd_data    = rd_data_q;
  assign dc_rd_data    = rd_data_q;
  assign ic_rd_valid   = ic_rd_valid_q;
  assign dc_rd_valid   = dc_rd_valid_q;
  assign ic_done       = ic_done_q;
  assign dc_done       = dc_done_q;
  assign grant         = grant_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_we    = req_we_q;
  assign mem_wr_valid  = wr_valid_q;
  // Write path is a direct pass-through so D sees acceptance in the same cycle.
  assign mem_wr_data   = wr_valid_q ? dc_wr_data : '0;
  assign dc_wr_ready   = wr_beat_c;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed self-checking bench for cache_refill_arbiter.
module tb_cache_refill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic [31:0] ic_rd_data;
  logic        ic_rd_valid, ic_done;
  logic        dc_req, dc_we;
  logic [31:0] dc_addr, dc_wr_data;
  logic        dc_wr_ready;
  logic [31:0] dc_rd_data;
  logic        dc_rd_valid, dc_done;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we, mem_wr_valid, mem_wr_ready;
  logic [31:0] mem_wr_data;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic [1:0]  grant;

  int checks   = 0;
  int failures = 0;

  cache_refill_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rd_data(ic_rd_data),
    .ic_rd_valid(ic_rd_valid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_ready(dc_wr_ready), .dc_rd_data(dc_rd_data), .dc_rd_valid(dc_rd_valid),
    .dc_done(dc_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_data(mem_wr_data),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Read data phase, entered at the first DATA cycle; ends back in IDLE.
  task automatic data_phase(input logic [1:0] exp_grant, input logic [31:0] base,
                            input bit drop_req);
    bit is_i = exp_grant[0];
    for (int i = 0; i < 4; i++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = base + 32'(i);
      cyc();
      check("rd_valid", 64'(is_i ? ic_rd_valid : dc_rd_valid), 64'(1));
      check("rd_valid_other", 64'(is_i ? dc_rd_valid : ic_rd_valid), 64'(0));
      check("rd_data", 64'(is_i ? ic_rd_data : dc_rd_data), 64'(base + 32'(i)));
      if (i == 3) check("done_early", 64'(ic_done | dc_done), 64'(0));
    end
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    cyc();
    check("done", 64'(is_i ? ic_done : dc_done), 64'(1));
    check("done_other", 64'(is_i ? dc_done : ic_done), 64'(0));
    check("grant_in_done", 64'(grant), 64'(exp_grant));
    check("rd_valid_in_done", 64'(ic_rd_valid | dc_rd_valid), 64'(0));
    if (drop_req) begin
      if (is_i) ic_req = 1'b0;
      else      dc_req = 1'b0;
    end
    cyc();
    check("done_clear", 64'(ic_done | dc_done), 64'(0));
    check("grant_idle", 64'(grant), 64'(0));
  endtask

  // Full read from IDLE with request already driven; memory accepts immediately.
  task automatic run_read(input logic [1:0] exp_grant, input logic [31:0] exp_addr,
                          input logic [31:0] base, input bit drop_req);
    mem_req_ready = 1'b1;
    cyc();
    check("grant", 64'(grant), 64'(exp_grant));
    check("req_valid", 64'(mem_req_valid), 64'(1));
    check("req_addr", 64'(mem_req_addr), 64'(exp_addr));
    check("req_we", 64'(mem_req_we), 64'(0));
    cyc();
    mem_req_ready = 1'b0;
    check("req_valid_off", 64'(mem_req_valid), 64'(0));
    data_phase(exp_grant, base, drop_req);
  endtask

  int pulses;

  initial begin
    rst = 1'b1; ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0; dc_addr = '0;
    dc_wr_data = '0; mem_req_ready = 0; mem_wr_ready = 0; mem_rd_valid = 0; mem_rd_data = '0;
    cyc(); cyc();
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_req_valid", 64'(mem_req_valid), 64'(0));
    check("rst_outs", 64'({ic_rd_valid, ic_done, dc_rd_valid, dc_done, mem_wr_valid, dc_wr_ready}), 64'(0));
    check("rst_addr", 64'(mem_req_addr), 64'(0));
    rst = 1'b0;
    cyc();

    // I fill alone
    ic_req = 1'b1; ic_addr = 32'h1004;
    run_read(2'b01, 32'h1000, 32'hA0, 1'b1);

    // D write-back with alternating memory backpressure
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h2010; mem_req_ready = 1'b1;
    cyc();
    check("wb_grant", 64'(grant), 64'(2'b10));
    check("wb_req_we", 64'(mem_req_we), 64'(1));
    check("wb_req_addr", 64'(mem_req_addr), 64'(32'h2010));
    cyc();
    mem_req_ready = 1'b0;
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      mem_wr_ready = (k % 2 == 0);
      dc_wr_data   = 32'hD0 + 32'(pulses);
      #1;
      check("wb_wr_valid", 64'(mem_wr_valid), 64'(1));
      check("wb_wr_ready", 64'(dc_wr_ready), 64'(k % 2 == 0));
      check("wb_wr_data", 64'(mem_wr_data), 64'(32'hD0 + 32'(pulses)));
      if (dc_wr_ready) pulses++;
      @(posedge clk); #1;
    end
    mem_wr_ready = 1'b0;
    check("wb_pulses", 64'(pulses), 64'(4));
    check("wb_done", 64'(dc_done), 64'(1));
    check("wb_wr_valid_off", 64'(mem_wr_valid), 64'(0));
    dc_req = 1'b0; dc_we = 1'b0;
    cyc();
    check("wb_done_clear", 64'(dc_done), 64'(0));
    check("wb_grant_idle", 64'(grant), 64'(0));

    // Simultaneous requests: D first, then I
    ic_req = 1'b1; ic_addr = 32'h3008;
    dc_req = 1'b1; dc_addr = 32'h4000;
    run_read(2'b10, 32'h4000, 32'hB0, 1'b1);
    run_read(2'b01, 32'h3000, 32'hB8, 1'b1);

    // Starvation: three D grants, then I forced, then D again after clear
    ic_req = 1'b1; ic_addr = 32'h7000;
    dc_req = 1'b1; dc_addr = 32'h8000;
    run_read(2'b10, 32'h8000, 32'h10, 1'b0);
    run_read(2'b10, 32'h8000, 32'h20, 1'b0);
    run_read(2'b10, 32'h8000, 32'h30, 1'b0);
    run_read(2'b01, 32'h7000, 32'h40, 1'b0);
    run_read(2'b10, 32'h8000, 32'h50, 1'b1);
    run_read(2'b01, 32'h7000, 32'h60, 1'b1);

    // Reset after two of four read beats
    ic_req = 1'b1; ic_addr = 32'h5000; mem_req_ready = 1'b1;
    cyc();
    cyc();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rd_valid = 1'b1; mem_rd_data = 32'hE0 + 32'(i);
      cyc();
      check("rb_beat", 64'(ic_rd_data), 64'(32'hE0 + 32'(i)));
    end
    rst = 1'b1; ic_req = 1'b0; mem_rd_valid = 1'b0;
    cyc();
    check("rb_grant", 64'(grant), 64'(0));
    check("rb_outs", 64'({ic_rd_valid, ic_done, mem_req_valid, mem_wr_valid}), 64'(0));
    check("rb_data", 64'(ic_rd_data), 64'(0));
    rst = 1'b0;
    cyc();
    check("rb_no_done", 64'(ic_done), 64'(0));
    ic_req = 1'b1; ic_addr = 32'h5040;
    run_read(2'b01, 32'h5040, 32'hC0, 1'b1);

    // Address-phase stall with spurious read beats that must be ignored
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h6004;
    mem_req_ready = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = 32'hBAD;
    cyc();
    for (int s = 0; s < 5; s++) begin
      check("st_valid", 64'(mem_req_valid), 64'(1));
      check("st_addr", 64'(mem_req_addr), 64'(32'h6000));
      check("st_rd_valid", 64'(dc_rd_valid), 64'(0));
      cyc();
    end
    mem_req_ready = 1'b1; mem_rd_valid = 1'b0;
    cyc();
    mem_req_ready = 1'b0;
    check("st_accepted", 64'(mem_req_valid), 64'(0));
    check("st_rd_valid_after", 64'(dc_rd_valid), 64'(0));
    data_phase(2'b10, 32'hF0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
